sa_ctrl: RTL and testbench

//  Sequencer for one SA_R x SA_C systolic-array matmul pass (C = X * W, inner dim K).
//  - Accepts a request and issues K column/row reads to the X and W tile buffers.
//  - Skews the returned vectors into the array edges and drives the array's start/end flags.
//  - Waits out the array drain, then pulses done; the array outputs then hold the result.
//  - Sits between the MHA tile scheduler and the SA instance.

---
 rtl/sa_ctrl.sv | 155 +++++++++++++++
 tb/tb_sa_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_ctrl.sv
// rtl/sa_ctrl.sv - systolic-array matmul pass sequencer: tile reads, edge skew, start/end/done
// Optional accumulate mode: define SA_CTRL_ACC_EN to add the acc port.
module sa_ctrl #(
    parameter int D_W    = 8,
    parameter int SA_R   = 16,
    parameter int SA_C   = 16,
    parameter int KW     = 8,
    parameter int PE_LAT = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [KW-1:0]         k,
`ifdef SA_CTRL_ACC_EN
    input  logic                  acc,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [KW-1:0]         rd_addr,
    input  logic [SA_R*D_W-1:0]   x_rdata,
    input  logic [SA_C*D_W-1:0]   w_rdata,
    output logic                  sa_start,
    output logic                  sa_end,
    output logic [SA_R*D_W-1:0]   sa_x,
    output logic [SA_C*D_W-1:0]   sa_w
);

    localparam int DRAIN_N = SA_R + SA_C + PE_LAT;
    localparam int DCW     = $clog2(DRAIN_N + 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_N - 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t         state, state_nx;
    logic [KW-1:0]  k_q;
    logic [KW-1:0]  addr_q;
    logic [DCW-1:0] drain_q;
    logic           rd_vld;
    logic           keep_sums;

`ifdef SA_CTRL_ACC_EN
    logic acc_q;
    always_ff @(posedge clk) begin
        if (rst)
            acc_q <= 1'b0;
        else if (state == S_IDLE && req)
            acc_q <= acc;
    end
    assign keep_sums = acc_q;
`else
    assign keep_sums = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            k_q     <= '0;
            addr_q  <= '0;
            drain_q <= '0;
            rd_vld  <= 1'b0;
        end else begin
            state  <= state_nx;
            rd_vld <= rd_en;
            if (state == S_IDLE && req)
                k_q <= k;
            addr_q  <= (state == S_FEED)  ? addr_q + 1'b1  : '0;
            drain_q <= (state == S_DRAIN) ? drain_q + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        sa_start = 1'b0;
        sa_end   = 1'b0;
        case (state)
            S_IDLE: begin
                sa_end = 1'b1;
                if (req)
                    state_nx = S_CLEAR;
            end
            S_CLEAR: begin
                busy     = 1'b1;
                sa_start = !keep_sums;
                state_nx = (k_q == '0) ? S_DRAIN : S_FEED;
            end
            S_FEED: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                rd_addr = addr_q;
                if (addr_q == k_q - 1'b1)
                    state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (drain_q == DRAIN_LAST)
                    state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                sa_end   = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Lane i is i+1 registers deep after the read-data stage, giving the diagonal wavefront.
    for (genvar i = 0; i < SA_R; i++) begin : g_x
        logic [D_W-1:0] d [0:i];
        logic           v [0:i];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s <= i; s++) begin
                    d[s] <= '0;
                    v[s] <= 1'b0;
                end
            end else begin
                d[0] <= x_rdata[i*D_W +: D_W];
                v[0] <= rd_vld;
                for (int s = 1; s <= i; s++) begin
                    d[s] <= d[s-1];
                    v[s] <= v[s-1];
                end
            end
        end
        assign sa_x[i*D_W +: D_W] = v[i] ? d[i] : '0;
    end

    for (genvar j = 0; j < SA_C; j++) begin : g_w
        logic [D_W-1:0] d [0:j];
        logic           v [0:j];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s <= j; s++) begin
                    d[s] <= '0;
                    v[s] <= 1'b0;
                end
            end else begin
                d[0] <= w_rdata[j*D_W +: D_W];
                v[0] <= rd_vld;
                for (int s = 1; s <= j; s++) begin
                    d[s] <= d[s-1];
                    v[s] <= v[s-1];
                end
            end
        end
        assign sa_w[j*D_W +: D_W] = v[j] ? d[j] : '0;
    end

endmodule

// File: tb/tb_sa_ctrl.sv
// tb/tb_sa_ctrl.sv - directed bench for sa_ctrl on a 4x4 array with a behavioural PE grid
module tb_sa_ctrl;
    localparam int PE_LAT = 5;
    localparam int DN     = 4 + 4 + PE_LAT;

    logic        clk = 1'b0;
    logic        rst, req;
    logic [7:0]  k;
`ifdef SA_CTRL_ACC_EN
    logic        acc;
`endif
    logic        busy, done, rd_en, sa_start, sa_end;
    logic [7:0]  rd_addr;
    logic [31:0] x_rdata = '0;
    logic [31:0] w_rdata = '0;
    logic [31:0] sa_x, sa_w;

    int checks = 0;
    int failures = 0;

    logic signed [7:0] xm [0:3][0:7];
    logic signed [7:0] wm [0:7][0:3];
    int mbase = 0;
    int pacc [0:3][0:3];
    logic signed [7:0] xr [0:3][0:3];
    logic signed [7:0] wr [0:3][0:3];
    logic signed [7:0] xi, wi;

    sa_ctrl #(.D_W(8), .SA_R(4), .SA_C(4), .KW(8), .PE_LAT(PE_LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .k(k),
`ifdef SA_CTRL_ACC_EN
        .acc(acc),
`endif
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .x_rdata(x_rdata), .w_rdata(w_rdata),
        .sa_start(sa_start), .sa_end(sa_end), .sa_x(sa_x), .sa_w(sa_w)
    );

    always #5 clk = ~clk;

    // Tile buffers with one cycle of read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            for (int i = 0; i < 4; i++) begin
                x_rdata[i*8 +: 8] <= xm[i][(int'(rd_addr) + mbase) & 7];
                w_rdata[i*8 +: 8] <= wm[(int'(rd_addr) + mbase) & 7][i];
            end
        end
    end

    // Output-stationary PE grid: x moves right, w moves down, start clears the sums.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (j == 0) xi = sa_x[i*8 +: 8]; else xi = xr[i][j-1];
                if (i == 0) wi = sa_w[j*8 +: 8]; else wi = wr[i-1][j];
                xr[i][j] <= rst ? 8'sd0 : xi;
                wr[i][j] <= rst ? 8'sd0 : wi;
                if (rst || sa_start) pacc[i][j] <= 0;
                else                 pacc[i][j] <= pacc[i][j] + int'(xi) * int'(wi);
            end
        end
    end

    function automatic int gold(int i, int j, int k0, int kn);
        int s = 0;
        for (int kk = k0; kk < k0 + kn; kk++) s += int'(xm[i][kk]) * int'(wm[kk][j]);
        return s;
    endfunction

    task automatic fill_matmul();
        for (int i = 0; i < 4; i++)
            for (int kk = 0; kk < 8; kk++) begin
                xm[i][kk] = 8'(i*4 + kk + 1 - 8);
                wm[kk][i] = 8'(kk*3 - i*2 + 1);
            end
    endtask

    task automatic check_results(string name, int k0, int kn);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (pacc[i][j] !== gold(i, j, k0, kn)) begin
                    failures++;
                    $display("FAIL %s c[%0d][%0d] got=%0d exp=%0d", name, i, j, pacc[i][j], gold(i, j, k0, kn));
                end
            end
    endtask

    task automatic check_idle_outputs(string name);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0 || rd_addr !== 8'd0 ||
            sa_start !== 1'b0 || sa_end !== 1'b1 || sa_x !== 32'd0 || sa_w !== 32'd0) begin
            failures++;
            $display("FAIL %s got busy=%b done=%b rd_en=%b addr=%0d start=%b end=%b x=%h w=%h exp 0 0 0 0 0 1 0 0",
                     name, busy, done, rd_en, rd_addr, sa_start, sa_end, sa_x, sa_w);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; k = 8'd0;
`ifdef SA_CTRL_ACC_EN
        acc = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_state");
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("idle_after_reset");
    endtask

    task automatic test_basic();
        logic exp_rd;
        fill_matmul();
        mbase = 0;
        @(negedge clk); req = 1'b1; k = 8'd4;
        for (int t = 1; t <= 21; t++) begin
            @(negedge clk);
            if (t == 1) begin
                req = 1'b0;
                checks++;
                if (sa_start !== 1'b1 || busy !== 1'b1 || sa_end !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_clear t=%0d got start=%b busy=%b end=%b exp 1 1 0", t, sa_start, busy, sa_end);
                end
            end
            exp_rd = (t >= 2 && t <= 5);
            checks++;
            if (rd_en !== exp_rd || (exp_rd && rd_addr !== 8'(t - 2))) begin
                failures++;
                $display("FAIL basic_read t=%0d got en=%b addr=%0d exp en=%b addr=%0d", t, rd_en, rd_addr, exp_rd, t - 2);
            end
            if (t == 6 || t == 7) begin
                checks++;
                if (sa_x[31:24] !== ((t == 7) ? xm[3][0] : 8'd0) || sa_w[31:24] !== ((t == 7) ? wm[0][3] : 8'd0)) begin
                    failures++;
                    $display("FAIL basic_row3_first t=%0d got x3=%h w3=%h", t, sa_x[31:24], sa_w[31:24]);
                end
            end
            checks++;
            if (done !== (t == 6 + 4 + 4 + PE_LAT)) begin
                failures++;
                $display("FAIL basic_done t=%0d got=%b exp=%b", t, done, (t == 6 + 4 + 4 + PE_LAT));
            end
            if (t == 6 + 4 + 4 + PE_LAT) begin
                checks++;
                if (busy !== 1'b0 || sa_end !== 1'b1) begin
                    failures++;
                    $display("FAIL basic_done_flags got busy=%b end=%b exp 0 1", busy, sa_end);
                end
                check_results("basic_matmul", 0, 4);
            end
        end
    endtask

    task automatic test_k_zero();
        @(negedge clk); req = 1'b1; k = 8'd0;
        for (int t = 1; t <= 17; t++) begin
            @(negedge clk);
            if (t == 1) req = 1'b0;
            checks++;
            if (rd_en !== 1'b0 || done !== (t == 2 + DN)) begin
                failures++;
                $display("FAIL kzero t=%0d got rd_en=%b done=%b exp 0 %b", t, rd_en, done, (t == 2 + DN));
            end
            if (t == 2 + DN) begin
                checks++;
                if (pacc[0][0] !== 0 || pacc[3][3] !== 0 || pacc[1][2] !== 0 || sa_x !== 32'd0) begin
                    failures++;
                    $display("FAIL kzero_result got c00=%0d c33=%0d c12=%0d x=%h exp 0", pacc[0][0], pacc[3][3], pacc[1][2], sa_x);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic es, ed, er;
        @(negedge clk); req = 1'b1; k = 8'd1;
        for (int t = 1; t <= 36; t++) begin
            @(negedge clk);
            if (t == 3) k = 8'd2;
            if (t == 33) req = 1'b0;
            es = (t == 1 || t == 18);
            ed = (t == 16 || t == 34);
            er = (t == 2 || t == 19 || t == 20);
            checks++;
            if (sa_start !== es || done !== ed || rd_en !== er) begin
                failures++;
                $display("FAIL b2b t=%0d got start=%b done=%b rd_en=%b exp %b %b %b", t, sa_start, done, rd_en, es, ed, er);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit saw_done = 1'b0;
        @(negedge clk); req = 1'b1; k = 8'd4;
        for (int t = 1; t <= 30; t++) begin
            @(negedge clk);
            if (t == 1) req = 1'b0;
            if (t == 4) begin
                checks++;
                if (rd_en !== 1'b1 || rd_addr !== 8'd2) begin
                    failures++;
                    $display("FAIL midrst_pre got rd_en=%b addr=%0d exp 1 2", rd_en, rd_addr);
                end
                rst = 1'b1;
            end
            if (t == 5) begin
                check_idle_outputs("midrst_outputs");
                rst = 1'b0;
            end
            if (t > 5 && done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL midrst_no_done got done seen exp none");
        end
        test_basic();
    endtask

    task automatic test_skew();
        logic [7:0] ex, ew;
        for (int i = 0; i < 4; i++)
            for (int kk = 0; kk < 8; kk++) begin
                xm[i][kk] = 8'(8'h11 * (i + 1));
                wm[kk][i] = 8'(8'h0F + i);
            end
        @(negedge clk); req = 1'b1; k = 8'd3;
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            if (t == 1) req = 1'b0;
            for (int i = 0; i < 4; i++) begin
                ex = (t >= 4 + i && t <= 3 + i + 3) ? 8'(8'h11 * (i + 1)) : 8'd0;
                ew = (t >= 4 + i && t <= 3 + i + 3) ? 8'(8'h0F + i) : 8'd0;
                checks++;
                if (sa_x[i*8 +: 8] !== ex || sa_w[i*8 +: 8] !== ew) begin
                    failures++;
                    $display("FAIL skew t=%0d lane=%0d got x=%h w=%h exp x=%h w=%h", t, i, sa_x[i*8 +: 8], sa_w[i*8 +: 8], ex, ew);
                end
            end
        end
    endtask

`ifdef SA_CTRL_ACC_EN
    task automatic test_acc();
        fill_matmul();
        for (int p = 0; p < 2; p++) begin
            mbase = 2 * p;
            @(negedge clk); req = 1'b1; k = 8'd2; acc = (p == 1);
            for (int t = 1; t <= 2 + 2 + DN; t++) begin
                @(negedge clk);
                if (t == 1) begin req = 1'b0; acc = 1'b0; end
                checks++;
                if (sa_start !== (p == 0 && t == 1)) begin
                    failures++;
                    $display("FAIL acc_start pass=%0d t=%0d got=%b exp=%b", p, t, sa_start, (p == 0 && t == 1));
                end
            end
            checks++;
            if (done !== 1'b1) begin
                failures++;
                $display("FAIL acc_done pass=%0d got=%b exp=1", p, done);
            end
        end
        check_results("acc_matmul", 0, 4);
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_k_zero();
        test_back_to_back();
        test_reset_mid();
        test_skew();
`ifdef SA_CTRL_ACC_EN
        test_acc();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
